// File: rtl/register_file_op.sv
// register_file_op: multi-register bank with an in-place ALU write port, two read ports and carry/zero flags
module register_file_op #(
  parameter int              WIDTH       = 16,
  parameter int              DEPTH       = 4,
  parameter int              ADDR_WIDTH  = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit              BYPASS      = 1'b0
) (
  input  logic                  clock,
  input  logic                  input_clear_n,
  input  logic                  input_clock_enable,
  input  logic                  input_flush,
  input  logic                  input_write_enable,
  input  logic [ADDR_WIDTH-1:0] input_write_addr,
  input  logic [2:0]            input_op,
  input  logic [WIDTH-1:0]      input_d,
  input  logic [ADDR_WIDTH-1:0] input_read_addr_a,
  input  logic [ADDR_WIDTH-1:0] input_read_addr_b,
  output logic [WIDTH-1:0]      output_q_a,
  output logic [WIDTH-1:0]      output_q_b,
  output logic                  output_carry,
  output logic                  output_zero
);
  localparam logic [2:0] OP_LOAD = 3'b001, OP_INC = 3'b010, OP_DEC = 3'b011,
                         OP_SHL  = 3'b100, OP_SHR = 3'b101, OP_CLR = 3'b110;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q, carry_d, zero_q, zero_d;
  logic [WIDTH-1:0] cur, res;
  logic             res_c, exec;
  assign exec = input_write_enable && (32'(input_write_addr) < DEPTH) &&
                (input_op != 3'b000) && (input_op != 3'b111);
  always_comb begin
    cur = '0;
    for (int i = 0; i < DEPTH; i++)
      if (input_write_addr == ADDR_WIDTH'(i)) cur = regs_q[i];
  end
  always_comb begin
    {res_c, res} = {1'b0, cur};
    case (input_op)
      OP_LOAD: {res_c, res} = {1'b0, input_d};
      OP_INC:  {res_c, res} = {1'b0, cur} + (WIDTH+1)'(1);
      OP_DEC:  {res_c, res} = {1'b0, cur} - (WIDTH+1)'(1);
      OP_SHL:  {res_c, res} = {cur[WIDTH-1], cur[WIDTH-2:0], 1'b0};
      OP_SHR:  {res_c, res} = {cur[0], 1'b0, cur[WIDTH-1:1]};
      OP_CLR:  {res_c, res} = '0;
      default: {res_c, res} = {1'b0, cur};
    endcase
  end
  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (input_clock_enable && input_flush) begin
      for (int i = 0; i < DEPTH; i++) regs_d[i] = RESET_VALUE;
      carry_d = 1'b0;
      zero_d  = (RESET_VALUE == '0);
    end else if (input_clock_enable && exec) begin
      for (int i = 0; i < DEPTH; i++)
        if (input_write_addr == ADDR_WIDTH'(i)) regs_d[i] = res;
      carry_d = res_c;
      zero_d  = (res == '0);
    end
  end
  // Forwarding reads the next-state array, which already folds in CE, flush and write
  always_comb begin
    output_q_a = '0;
    output_q_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (input_read_addr_a == ADDR_WIDTH'(i)) output_q_a = BYPASS ? regs_d[i] : regs_q[i];
      if (input_read_addr_b == ADDR_WIDTH'(i)) output_q_b = BYPASS ? regs_d[i] : regs_q[i];
    end
  end
  always_ff @(posedge clock or negedge input_clear_n) begin
    if (!input_clear_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VALUE;
      carry_q <= 1'b0;
      zero_q  <= (RESET_VALUE == '0);
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end
  assign output_carry = carry_q;
  assign output_zero  = zero_q;
endmodule
